// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-ported data memory between port A and port B.
// Latency: grant edge, one ACCESS cycle with strobes, one DONE cycle; a new grant every 3 cycles.
// Backpressure: a requester holds req until its done pulse; the losing port simply stays pending.
module dmem_arbiter #(
    parameter logic [31:0] BASE_ADDR = 32'h80,
    parameter int unsigned DEPTH     = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    output logic        a_done,
    output logic        a_err,
    output logic [31:0] a_rdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic        b_done,
    output logic        b_err,
    output logic [31:0] b_rdata,
    output logic        busy,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Highest legal word address, computed one bit wider so the window cannot wrap.
    localparam logic [32:0] LAST_ADDR = {1'b0, BASE_ADDR} + 33'(4 * DEPTH) - 33'd4;

    state_t      state_q, state_d;
    logic        sel_b_q, sel_b_d;     // latched winner: 1 = port B
    logic        last_b_q, last_b_d;   // port served most recently: 1 = port B
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        a_done_q, a_done_d;
    logic        b_done_q, b_done_d;
    logic        a_err_q, a_err_d;
    logic        b_err_q, b_err_d;
    logic [31:0] a_rdata_q, a_rdata_d;
    logic [31:0] b_rdata_q, b_rdata_d;
    logic        busy_q, busy_d;

    logic        grant_b;
    logic        addr_ok;

    // B wins when it is the only requester, or on a tie when A was served last.
    assign grant_b = b_req & (~a_req | ~last_b_q);

    // The latched address must be word aligned and inside the memory window.
    assign addr_ok = (addr_q[1:0] == 2'b00)
                   && (addr_q >= BASE_ADDR)
                   && ({1'b0, addr_q} <= LAST_ADDR);

    // Memory strobes are decoded straight from the state so a reset kills them at once.
    assign mem_we = (state_q == ACCESS) & addr_ok & we_q;
    assign mem_re = (state_q == ACCESS) & addr_ok & ~we_q;

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign a_done    = a_done_q;
    assign b_done    = b_done_q;
    assign a_err     = a_err_q;
    assign b_err     = b_err_q;
    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;
    assign busy      = busy_q;

    // Next-state and next-output decode for the IDLE/ACCESS/DONE sequence.
    always_comb begin
        state_d   = state_q;
        sel_b_d   = sel_b_q;
        last_b_d  = last_b_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        a_done_d  = 1'b0;
        b_done_d  = 1'b0;
        a_err_d   = 1'b0;
        b_err_d   = 1'b0;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        case (state_q)
            IDLE: begin
                if (a_req || b_req) begin
                    sel_b_d  = grant_b;
                    last_b_d = grant_b;
                    we_d     = grant_b ? b_we    : a_we;
                    addr_d   = grant_b ? b_addr  : a_addr;
                    wdata_d  = grant_b ? b_wdata : a_wdata;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                state_d = DONE;
                // Done/err/rdata are registered here so they appear together in DONE.
                // A rejected read shows zero data alongside its error flag.
                if (sel_b_q) begin
                    b_done_d = 1'b1;
                    b_err_d  = ~addr_ok;
                    if (!we_q) begin
                        b_rdata_d = addr_ok ? mem_rdata : 32'h0;
                    end
                end else begin
                    a_done_d = 1'b1;
                    a_err_d  = ~addr_ok;
                    if (!we_q) begin
                        a_rdata_d = addr_ok ? mem_rdata : 32'h0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset returns every registered output to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_b_q   <= 1'b0;
            last_b_q  <= 1'b1;
            we_q      <= 1'b0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            a_done_q  <= 1'b0;
            b_done_q  <= 1'b0;
            a_err_q   <= 1'b0;
            b_err_q   <= 1'b0;
            a_rdata_q <= 32'h0;
            b_rdata_q <= 32'h0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_b_q   <= sel_b_d;
            last_b_q  <= last_b_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            a_done_q  <= a_done_d;
            b_done_q  <= b_done_d;
            a_err_q   <= a_err_d;
            b_err_q   <= b_err_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
            busy_q    <= busy_d;
        end
    end

endmodule
